// File: rtl/pulse_cfg_pkg.sv
// Shared constants for the pulse-generator configuration scheduler.
// Holds the settings width default, FSM state codes and the entry-index layout.
package pulse_cfg_pkg;

   localparam int DEF_SETTINGS_WIDTH = 30;

   // Each channel owns two shadow entries: index = {channel, sel}.
   localparam int   ENTRIES_PER_CH = 2;
   localparam logic SEL_DELAY      = 1'b0;
   localparam logic SEL_WIDTH      = 1'b1;

   // FSM state codes.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_SCAN    = 2'd1;
   localparam state_t ST_HOLDOFF = 2'd2;

endpackage

// File: rtl/pulse_cfg_shadow_bank.sv
// Shadow register bank: one SETTINGS_WIDTH entry plus a dirty bit per index.
// A write always wins over a scan clear of the same entry, so a value written
// while its own slot is being pushed stays dirty for the next pass.
// Optional readback port under PULSE_CFG_READBACK_EN.
module pulse_cfg_shadow_bank
   import pulse_cfg_pkg::*;
#(
   parameter int ENTRIES        = 16,
   parameter int SETTINGS_WIDTH = DEF_SETTINGS_WIDTH,
   parameter int AW             = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [AW-1:0]             wr_addr,
   input  logic [SETTINGS_WIDTH-1:0] wr_data,
   input  logic [AW-1:0]             scan_addr,
   input  logic                      scan_clear,
   output logic [SETTINGS_WIDTH-1:0] scan_data,
   output logic                      scan_dirty
`ifdef PULSE_CFG_READBACK_EN
   ,
   input  logic [AW-1:0]             rd_addr,
   output logic [31:0]               rd_data
`endif
);

   logic [ENTRIES-1:0][SETTINGS_WIDTH-1:0] shadow;
   logic [ENTRIES-1:0]                     dirty;

   // Store writes and track dirty bits; out-of-range addresses match no entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= '0;
         dirty  <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (wr_en && (wr_addr == AW'(i))) begin
               shadow[i] <= wr_data;
               dirty[i]  <= 1'b1;
            end else if (scan_clear && (scan_addr == AW'(i))) begin
               dirty[i]  <= 1'b0;
            end
         end
      end
   end

   assign scan_data  = shadow[scan_addr];
   assign scan_dirty = dirty[scan_addr];

`ifdef PULSE_CFG_READBACK_EN
   // Combinational readback: dirty flag in bit 31, setting zero-extended below.
   always_comb begin
      rd_data = '0;
      if (int'(rd_addr) < ENTRIES) begin
         rd_data     = 32'(shadow[rd_addr]);
         rd_data[31] = dirty[rd_addr];
      end
   end
`endif

endmodule

// File: rtl/pulse_config_scheduler.sv
// Shadow-register front end for CHANNELS pulse generators.
// CPU writes mark entries dirty; a commit runs one pass that pushes each dirty
// entry in its own slot, then a GAP_CYCLES holdoff spaces out the next pass.
// Optional macro PULSE_CFG_READBACK_EN adds the cpuReadData readback port.
module pulse_config_scheduler
   import pulse_cfg_pkg::*;
#(
   parameter int CHANNELS       = 8,
   parameter int SETTINGS_WIDTH = DEF_SETTINGS_WIDTH,
   parameter int GAP_CYCLES     = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cpuWriteStrobe,
   input  logic [$clog2(2*CHANNELS)-1:0]  cpuAddr,
   input  logic [31:0]                    cpuData,
   input  logic                           commit,
   output logic                           busy,
   output logic                           done,
   output logic                           pending,
   output logic [31:0]                    cfgData,
   output logic [CHANNELS-1:0]            cfgDelayStrobe,
   output logic [CHANNELS-1:0]            cfgWidthStrobe
`ifdef PULSE_CFG_READBACK_EN
   ,
   output logic [31:0]                    cpuReadData
`endif
);

   localparam int            ENTRIES  = ENTRIES_PER_CH * CHANNELS;
   localparam int            AW       = $clog2(ENTRIES);
   localparam int            HW       = $clog2(GAP_CYCLES + 1);
   localparam logic [AW-1:0] LAST_IDX = AW'(ENTRIES - 1);
   localparam logic [HW-1:0] GAP_V    = HW'(GAP_CYCLES);

   state_t                    state;
   logic [AW-1:0]             idx;
   logic [AW-1:0]             idx_chan;
   logic [HW-1:0]             holdoff;
   logic [SETTINGS_WIDTH-1:0] scan_data;
   logic                      scan_dirty;
   logic                      push;
   logic [CHANNELS-1:0]       dly_next;
   logic [CHANNELS-1:0]       wid_next;
   logic                      unused_data_bits;

   // Upper data bits are dropped on purpose.
   assign unused_data_bits = ^cpuData;

   assign push     = (state == ST_SCAN) && scan_dirty;
   assign idx_chan = idx >> 1;

   pulse_cfg_shadow_bank #(
      .ENTRIES        (ENTRIES),
      .SETTINGS_WIDTH (SETTINGS_WIDTH),
      .AW             (AW)
   ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (cpuWriteStrobe),
      .wr_addr    (cpuAddr),
      .wr_data    (cpuData[SETTINGS_WIDTH-1:0]),
      .scan_addr  (idx),
      .scan_clear (push),
      .scan_data  (scan_data),
      .scan_dirty (scan_dirty)
`ifdef PULSE_CFG_READBACK_EN
      ,
      .rd_addr    (cpuAddr),
      .rd_data    (cpuReadData)
`endif
   );

   // Pass sequencing: IDLE -> SCAN (one slot per entry) -> HOLDOFF -> IDLE.
   // A request waiting at the end of holdoff starts straight away so the next
   // pass begins exactly GAP_CYCLES after done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         idx     <= '0;
         holdoff <= '0;
         pending <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (commit || pending) begin
                  state   <= ST_SCAN;
                  idx     <= '0;
                  pending <= 1'b0;
               end
            end
            ST_SCAN: begin
               if (commit) pending <= 1'b1;
               if (idx == LAST_IDX) begin
                  state   <= ST_HOLDOFF;
                  holdoff <= GAP_V;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_HOLDOFF: begin
               if (holdoff <= HW'(1)) begin
                  holdoff <= '0;
                  if (commit || pending) begin
                     state   <= ST_SCAN;
                     idx     <= '0;
                     pending <= 1'b0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  holdoff <= holdoff - 1'b1;
                  if (commit) pending <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Strobe decode for the entry under the scan pointer: sel picks the vector,
   // channel picks the bit. At most one bit is set.
   always_comb begin
      dly_next = '0;
      wid_next = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         dly_next[c] = push && (idx[0] == SEL_DELAY) && (idx_chan == AW'(c));
         wid_next[c] = push && (idx[0] == SEL_WIDTH) && (idx_chan == AW'(c));
      end
   end

   // Registered outputs, one cycle behind the scan pointer; done marks the
   // first holdoff cycle. cfgData holds its value on clean slots.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy           <= 1'b0;
         done           <= 1'b0;
         cfgData        <= '0;
         cfgDelayStrobe <= '0;
         cfgWidthStrobe <= '0;
      end else begin
         busy           <= (state == ST_SCAN);
         done           <= (state == ST_HOLDOFF) && (holdoff == GAP_V);
         cfgDelayStrobe <= dly_next;
         cfgWidthStrobe <= wid_next;
         if (push) cfgData <= 32'(scan_data);
      end
   end

endmodule

// File: tb/tb_pulse_config_scheduler.sv
// Self-checking bench for pulse_config_scheduler (CHANNELS=8, GAP_CYCLES=16).
// The reference model keeps the shadow values and dirty flags as plain arrays
// and replays each pass slot by slot in order; with PULSE_CFG_READBACK_EN
// defined the readback port is exercised as well.
module tb_pulse_config_scheduler;

   localparam int          C    = 8;
   localparam int          N    = 2 * C;
   localparam int          GAP  = 16;
   localparam logic [31:0] MASK = 32'h3FFF_FFFF;

   logic         clk = 1'b0;
   logic         rst;
   logic         cpuWriteStrobe;
   logic [3:0]   cpuAddr;
   logic [31:0]  cpuData;
   logic         commit;
   logic         busy, done, pending;
   logic [31:0]  cfgData;
   logic [C-1:0] cfgDelayStrobe, cfgWidthStrobe;
`ifdef PULSE_CFG_READBACK_EN
   logic [31:0]  cpuReadData;
`endif

   pulse_config_scheduler #(.CHANNELS(C), .SETTINGS_WIDTH(30), .GAP_CYCLES(GAP)) dut (
      .clk            (clk),
      .rst            (rst),
      .cpuWriteStrobe (cpuWriteStrobe),
      .cpuAddr        (cpuAddr),
      .cpuData        (cpuData),
      .commit         (commit),
      .busy           (busy),
      .done           (done),
      .pending        (pending),
      .cfgData        (cfgData),
      .cfgDelayStrobe (cfgDelayStrobe),
      .cfgWidthStrobe (cfgWidthStrobe)
`ifdef PULSE_CFG_READBACK_EN
      ,
      .cpuReadData    (cpuReadData)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [31:0] shadow_m [N];
   bit          dirty_m  [N];
   logic [31:0] last_data;

   // Per-slot stimulus during a pass: write/commit sampled on the edge that
   // scans entry k.
   bit          sched_v [N];
   int          sched_a [N];
   logic [31:0] sched_d [N];
   bit          sched_c [N];

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         shadow_m[i] = '0;
         dirty_m[i]  = 1'b0;
      end
      last_data = '0;
   endtask

   task automatic clear_sched();
      for (int i = 0; i < N; i++) begin
         sched_v[i] = 1'b0;
         sched_a[i] = 0;
         sched_d[i] = '0;
         sched_c[i] = 1'b0;
      end
   endtask

   task automatic drive_sched(input int k);
      cpuWriteStrobe = sched_v[k];
      cpuAddr        = 4'(sched_a[k]);
      cpuData        = sched_d[k];
      commit         = sched_c[k];
   endtask

   task automatic write_entry(input int a, input logic [31:0] d);
      cpuWriteStrobe = 1'b1;
      cpuAddr        = 4'(a);
      cpuData        = d;
      @(posedge clk);
      #1;
      cpuWriteStrobe = 1'b0;
      shadow_m[a] = d & MASK;
      dirty_m[a]  = 1'b1;
   endtask

   task automatic wait_holdoff();
      repeat (GAP) @(posedge clk);
      #1;
   endtask

   // Commit one pass and compare every slot and the done cycle with the model.
   task automatic run_pass(input string tag);
      logic [C-1:0] exp_d, exp_w;
      commit = 1'b1;
      @(posedge clk);
      #1;
      commit = 1'b0;
      drive_sched(0);
      for (int k = 0; k < N; k++) begin
         @(posedge clk);
         exp_d = '0;
         exp_w = '0;
         if (dirty_m[k]) begin
            if (k % 2 == 0) exp_d[k/2] = 1'b1;
            else            exp_w[k/2] = 1'b1;
            last_data  = shadow_m[k];
            dirty_m[k] = 1'b0;
         end
         if (sched_v[k]) begin
            shadow_m[sched_a[k]] = sched_d[k] & MASK;
            dirty_m[sched_a[k]]  = 1'b1;
         end
         #1;
         cpuWriteStrobe = 1'b0;
         commit         = 1'b0;
         if (k + 1 < N) drive_sched(k + 1);
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s slot %0d busy/done: got %b/%b want 1/0", tag, k, busy, done);
         end
         checks++;
         if (cfgDelayStrobe !== exp_d || cfgWidthStrobe !== exp_w) begin
            errors++;
            $display("FAIL %s slot %0d strobes: got d=%h w=%h want d=%h w=%h",
                     tag, k, cfgDelayStrobe, cfgWidthStrobe, exp_d, exp_w);
         end
         checks++;
         if (cfgData !== last_data) begin
            errors++;
            $display("FAIL %s slot %0d cfgData: got %h want %h", tag, k, cfgData, last_data);
         end
      end
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b1 || cfgDelayStrobe !== '0 || cfgWidthStrobe !== '0) begin
         errors++;
         $display("FAIL %s done cycle: got busy=%b done=%b d=%h w=%h want 0 1 0 0",
                  tag, busy, done, cfgDelayStrobe, cfgWidthStrobe);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || pending !== 1'b0 || cfgData !== 32'h0 ||
          cfgDelayStrobe !== '0 || cfgWidthStrobe !== '0) begin
         errors++;
         $display("FAIL reset outputs: got busy=%b done=%b pend=%b data=%h d=%h w=%h want all 0",
                  busy, done, pending, cfgData, cfgDelayStrobe, cfgWidthStrobe);
      end
   endtask

   task automatic test_idle_commit();
      clear_sched();
      run_pass("idle_commit");
      wait_holdoff();
   endtask

   task automatic test_single_write();
      write_entry(5, 32'h0000_0123);
      clear_sched();
      run_pass("single_write");
      wait_holdoff();
      run_pass("single_clean");
      wait_holdoff();
   endtask

   task automatic test_scan_writes();
      write_entry(4, 32'h0000_AAAA);
      clear_sched();
      sched_v[4] = 1'b1; sched_a[4] = 4; sched_d[4] = 32'h0000_BBBB;
      run_pass("same_index");
      wait_holdoff();
      clear_sched();
      sched_v[4] = 1'b1; sched_a[4] = 9; sched_d[4] = 32'hFFFF_9999;
      run_pass("write_above");
      wait_holdoff();
      clear_sched();
      sched_v[4] = 1'b1; sched_a[4] = 2; sched_d[4] = 32'h0000_2222;
      run_pass("write_below");
      wait_holdoff();
      clear_sched();
      run_pass("below_next");
      wait_holdoff();
   endtask

   task automatic test_multi_commit();
      int n, strobe_cnt, busy_bad;
      clear_sched();
      sched_c[2] = 1'b1;
      sched_c[5] = 1'b1;
      sched_c[9] = 1'b1;
      run_pass("multi_commit");
      checks++;
      if (pending !== 1'b1) begin
         errors++;
         $display("FAIL multi_commit pending: got %b want 1", pending);
      end
      n = 0;
      while (n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (busy === 1'b1) break;
      end
      checks++;
      if (n != GAP) begin
         errors++;
         $display("FAIL multi_commit gap: got %0d cycles want %0d", n, GAP);
      end
      strobe_cnt = 0;
      busy_bad   = 0;
      for (int i = 0; i < N; i++) begin
         if (|cfgDelayStrobe || |cfgWidthStrobe) strobe_cnt++;
         if (busy !== 1'b1) busy_bad++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (strobe_cnt != 0 || busy_bad != 0 || done !== 1'b1 || pending !== 1'b0) begin
         errors++;
         $display("FAIL second_pass: got strobes=%0d busy_gaps=%0d done=%b pend=%b want 0 0 1 0",
                  strobe_cnt, busy_bad, done, pending);
      end
      busy_bad = 0;
      repeat (GAP + 8) begin
         @(posedge clk);
         #1;
         if (busy !== 1'b0) busy_bad++;
      end
      checks++;
      if (busy_bad != 0) begin
         errors++;
         $display("FAIL third_pass: got %0d busy cycles want 0", busy_bad);
      end
   endtask

   task automatic test_reset_mid_pass();
      int bad;
      write_entry(6, 32'h0000_0666);
      write_entry(7, 32'h0000_0777);
      commit = 1'b1;
      @(posedge clk);
      #1;
      commit = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || cfgDelayStrobe !== '0 || cfgWidthStrobe !== '0 || cfgData !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid outputs: got busy=%b d=%h w=%h data=%h want 0",
                  busy, cfgDelayStrobe, cfgWidthStrobe, cfgData);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      bad = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (|cfgDelayStrobe || |cfgWidthStrobe || busy) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_mid after release: got %0d active cycles want 0", bad);
      end
      clear_sched();
      run_pass("after_reset");
      wait_holdoff();
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         int nw;
         nw = $urandom_range(0, 5);
         for (int w = 0; w < nw; w++) write_entry($urandom_range(0, N - 1), $urandom);
         clear_sched();
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               sched_v[k] = 1'b1;
               sched_a[k] = $urandom_range(0, N - 1);
               sched_d[k] = $urandom;
            end
         end
         run_pass($sformatf("random%0d", it));
         wait_holdoff();
      end
   endtask

`ifdef PULSE_CFG_READBACK_EN
   task automatic test_readback();
      write_entry(0, 32'h3FFF_FFFF);
      cpuAddr = 4'd0;
      #1;
      checks++;
      if (cpuReadData !== 32'hBFFF_FFFF) begin
         errors++;
         $display("FAIL readback dirty: got %h want BFFFFFFF", cpuReadData);
      end
      clear_sched();
      run_pass("readback");
      cpuAddr = 4'd0;
      #1;
      checks++;
      if (cpuReadData !== 32'h3FFF_FFFF) begin
         errors++;
         $display("FAIL readback clean: got %h want 3FFFFFFF", cpuReadData);
      end
      wait_holdoff();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      cpuWriteStrobe = 1'b0;
      cpuAddr        = '0;
      cpuData        = '0;
      commit         = 1'b0;
      model_reset();
      clear_sched();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_idle_commit();
      test_single_write();
      test_scan_writes();
      test_multi_commit();
      test_reset_mid_pass();
      test_random();
`ifdef PULSE_CFG_READBACK_EN
      test_readback();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
